// File: rtl/fft_sink_framer_pkg.sv
// Shared types and constants for the FFT sink framer: state encoding, defaults, error code.
package fft_sink_framer_pkg;

    localparam int unsigned DATA_W_DEF       = 16;
    localparam int unsigned FFT_LEN_LOG2_DEF = 13;

    localparam logic [1:0] SINK_ERR_NONE = 2'b00;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/fft_sink_framer_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
module fft_sink_framer_fifo #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_wr;
    logic          do_rd;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fft_sink_framer.sv
// Frames a sample stream into Avalon-ST packets (sop/eop every 2**FFT_LEN_LOG2 beats) for an FFT sink.
module fft_sink_framer
    import fft_sink_framer_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned FFT_LEN_LOG2 = FFT_LEN_LOG2_DEF,
    parameter int unsigned FIFO_AW      = 4,
    parameter bit          COMPLEX_IN   = 1'b0,
    parameter bit          INVERSE      = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_real,
    input  logic [DATA_W-1:0]       in_imag,
    input  logic                    sink_ready,
    output logic                    sink_valid,
    output logic                    sink_sop,
    output logic                    sink_eop,
    output logic [DATA_W-1:0]       sink_real,
    output logic [DATA_W-1:0]       sink_imag,
    output logic [1:0]              sink_error,
    output logic                    inverse,
    output logic [FFT_LEN_LOG2:0]   fft_pts,
    output logic                    overflow,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned FIFO_W = 2 * DATA_W;
    localparam int unsigned IDX_W  = FFT_LEN_LOG2;
    localparam int unsigned PTS_W  = FFT_LEN_LOG2 + 1;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   load_idx;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_W-1:0]  fifo_wr_data;
    logic [FIFO_W-1:0]  fifo_rd_data;
    logic               wr_req_c;
    logic               load_c;
    logic               beat_c;

    assign sink_error   = SINK_ERR_NONE;
    assign inverse      = INVERSE;
    assign fft_pts      = PTS_W'(1) << FFT_LEN_LOG2;
    assign beat_c       = sink_valid && sink_ready;
    assign fifo_wr_data = {(COMPLEX_IN ? in_imag : DATA_W'(0)), in_real};

    fft_sink_framer_fifo #(
        .W  (FIFO_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_req_c),
        .wr_data (fifo_wr_data),
        .rd_en   (load_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // load_idx is the frame position of the next beat to load; at 0 with en low we sit on a boundary.
    always_comb begin
        state_next = state;
        wr_req_c   = in_valid && (en || (state == ST_STREAM));
        load_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && !fifo_empty) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                load_c = !fifo_empty && (!sink_valid || sink_ready) && (en || (load_idx != '0));
                if (!en && (load_idx == '0) && (!sink_valid || sink_ready)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_idx   <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            sink_real  <= '0;
            sink_imag  <= '0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (wr_req_c && fifo_full && !load_c) overflow <= 1'b1;
            if (beat_c && sink_eop) frame_cnt <= frame_cnt + 16'd1;
            if (load_c) begin
                sink_valid <= 1'b1;
                sink_real  <= fifo_rd_data[DATA_W-1:0];
                sink_imag  <= fifo_rd_data[FIFO_W-1:DATA_W];
                sink_sop   <= (load_idx == '0);
                sink_eop   <= (load_idx == '1);
                load_idx   <= load_idx + IDX_W'(1);
            end else if (beat_c) begin
                sink_valid <= 1'b0;
                sink_sop   <= 1'b0;
                sink_eop   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_sink_framer.sv
// Directed + random bench for fft_sink_framer with 8-point frames and a 4-entry FIFO.
module tb_fft_sink_framer;

    logic        clk;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic        sink_ready;
    logic        sink_valid;
    logic        sink_sop;
    logic        sink_eop;
    logic [15:0] sink_real;
    logic [15:0] sink_imag;
    logic [1:0]  sink_error;
    logic        inverse;
    logic [3:0]  fft_pts;
    logic        overflow;
    logic [15:0] frame_cnt;

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    logic [15:0] sb [$];
    int          beat_idx   = 0;
    int          exp_frames = 0;
    int          next_data  = 1;

    fft_sink_framer #(
        .DATA_W       (16),
        .FFT_LEN_LOG2 (3),
        .FIFO_AW      (2),
        .COMPLEX_IN   (1'b0),
        .INVERSE      (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in_valid   (in_valid),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .sink_ready (sink_ready),
        .sink_valid (sink_valid),
        .sink_sop   (sink_sop),
        .sink_eop   (sink_eop),
        .sink_real  (sink_real),
        .sink_imag  (sink_imag),
        .sink_error (sink_error),
        .inverse    (inverse),
        .fft_pts    (fft_pts),
        .overflow   (overflow),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input bit push);
        in_valid = 1'b1;
        in_real  = 16'(next_data);
        in_imag  = ~16'(next_data);
        if (push) sb.push_back(16'(next_data));
        next_data++;
    endtask

    task automatic send(input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            drive_sample(push);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        tick();
        tick();
    endtask

    // Scoreboard: every accepted beat must match the oldest expected sample and its frame position.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            beat_idx   = 0;
            exp_frames = 0;
        end else if (sink_valid && sink_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("beat_real", 32'(sink_real), 32'(sb.pop_front()));
                chk("beat_imag", 32'(sink_imag), 32'd0);
                chk("beat_sop", 32'(sink_sop), 32'(beat_idx == 0));
                chk("beat_eop", 32'(sink_eop), 32'(beat_idx == 7));
                if (beat_idx == 7) begin
                    beat_idx = 0;
                    exp_frames++;
                end else begin
                    beat_idx++;
                end
            end
        end
    end

    initial begin
        int f0;
        int n;
        int sent;
        int cyc;

        reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; sink_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", 32'(sink_valid), 32'd0);
        chk("rst_sop", 32'(sink_sop), 32'd0);
        chk("rst_eop", 32'(sink_eop), 32'd0);
        chk("rst_real", 32'(sink_real), 32'd0);
        chk("rst_imag", 32'(sink_imag), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("fft_pts", 32'(fft_pts), 32'd8);
        chk("sink_error", 32'(sink_error), 32'd0);
        chk("inverse", 32'(inverse), 32'd0);

        // Two back-to-back frames, samples 1..16.
        send(16, 1'b1);
        wait_drain(100);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("t1_overflow", 32'(overflow), 32'd0);

        // Five-cycle stall while holding beat idx 2 (sample 19).
        send(4, 1'b1);
        sink_ready = 1'b0;
        chk("t2_valid", 32'(sink_valid), 32'd1);
        chk("t2_real", 32'(sink_real), 32'd19);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive_sample(1'b1);
            else       in_valid = 1'b0;
            tick();
            chk("t2_hold_valid", 32'(sink_valid), 32'd1);
            chk("t2_hold_real", 32'(sink_real), 32'd19);
            chk("t2_hold_sop", 32'(sink_sop), 32'd0);
            chk("t2_hold_eop", 32'(sink_eop), 32'd0);
        end
        in_valid = 1'b0;
        sink_ready = 1'b1;
        send(1, 1'b1);
        wait_drain(100);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd3);

        // Overflow: reg + 4 FIFO entries hold 25..29, sample 30 is dropped.
        sink_ready = 1'b0;
        send(5, 1'b1);
        chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
        send(1, 1'b0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_held_real", 32'(sink_real), 32'd25);
        sink_ready = 1'b1;
        send(3, 1'b1);
        wait_drain(100);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd4);

        // en drops mid-frame: frame completes, two extra samples stay buffered until en returns.
        f0 = exp_frames;
        send(5, 1'b1);
        en = 1'b0;
        send(5, 1'b1);
        n = 0;
        while (exp_frames == f0 && n < 100) begin
            tick();
            n++;
        end
        chk("t4_frame_done", 32'(exp_frames), 32'(f0 + 1));
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive_sample(1'b0);
            else       in_valid = 1'b0;
            tick();
            chk("t4_idle_valid", 32'(sink_valid), 32'd0);
        end
        in_valid = 1'b0;
        en = 1'b1;
        send(6, 1'b1);
        wait_drain(100);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd6);

        // Reset while beat idx 5 is waiting in the output register.
        send(5, 1'b1);
        wait_drain(100);
        sink_ready = 1'b0;
        send(3, 1'b1);
        tick();
        chk("t5_pre_valid", 32'(sink_valid), 32'd1);
        chk("t5_pre_sop", 32'(sink_sop), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", 32'(sink_valid), 32'd0);
        chk("t5_sop", 32'(sink_sop), 32'd0);
        chk("t5_eop", 32'(sink_eop), 32'd0);
        chk("t5_real", 32'(sink_real), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
        sink_ready = 1'b1;
        send(8, 1'b1);
        wait_drain(100);
        chk("t5_frame_cnt_after", 32'(frame_cnt), 32'd1);

        // Random ready/valid over 100 frames; in_valid throttled so the FIFO cannot fill.
        sent = 0;
        cyc  = 0;
        while (sent < 800 && cyc < 20000) begin
            sink_ready = ($urandom_range(0, 9) < 7);
            if (sb.size() < 4 && $urandom_range(0, 9) < 6) begin
                drive_sample(1'b1);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        sink_ready = 1'b1;
        chk("t6_sent", 32'(sent), 32'd800);
        wait_drain(200);
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd101);
        chk("t6_frame_model", 32'(frame_cnt), 32'(exp_frames));
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_idx_aligned", 32'(beat_idx), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
